exhaustive_bist: RTL and testbench
==================================

# exhaustive_bist

Parametrised built-in self-test engine for small combinational blocks. On `start` it sweeps every input combination of an `N_IN`-bit function and holds each pattern for `DWELL` cycles. It compacts the function's `N_OUT`-bit response into a multiple-input signature register (MISR) and flags `pass` when the final signature equals `GOLDEN`. It sits between a sequencer/CPU handshake and any combinational unit under test. This replaces hand-written exhaustive stimulus lists with an on-chip, self-checking sweep.

## Interface
- `N_IN`, 4, number of inputs of the function under test; sweep length is 2^`N_IN`.
- `N_OUT`, 1, response width; `N_OUT` ≤ `SIG_W` (elaboration error otherwise).
- `DWELL`, 1, cycles each pattern is held; ≥ 1.
- `SIG_W`, 16, MISR width.
- `POLY`, 16'h1021, MISR feedback polynomial (`SIG_W` bits).
- `GOLDEN`, 16'h0000, expected final signature (`SIG_W` bits).
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `resp_i`  in  `N_OUT`  response of the function under test.
- `pat_o`  out  `N_IN`  current stimulus pattern.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse at sweep completion.
- `pass`  out  1  final signature == `GOLDEN`; held until next start or reset.
- `signature`  out  `SIG_W`  live MISR contents.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `start`=1 → RUN. Same edge: `pat_o`←0, dwell counter←0, `signature`←0, `pass`←0.
- RUN: dwell counter counts 0..`DWELL`-1. On the edge where it equals `DWELL`-1:
  - MISR update: sig ← {sig[`SIG_W`-2:0],1'b0} ^ (sig[`SIG_W`-1] ? `POLY` : 0) ^ zero-extended `resp_i`.
  - If `pat_o` = 2^`N_IN`-1 → DONE, `pat_o` held at max.
  - Otherwise `pat_o` increments and dwell counter resets to 0.
- DONE: `done`=1 for exactly one cycle. `pass` registered from (updated signature == `GOLDEN`) on the RUN→DONE edge, so it is valid while `done`=1. Next state IDLE.
- `start` is ignored in RUN and DONE. If `start` is held high continuously, a new sweep begins from the IDLE cycle after DONE.
- `busy` = (state == RUN). `signature` stays readable after completion until the next start.
- Counter arithmetic: `pat_o` is `N_IN` bits and never wraps through 0 within a sweep. The dwell counter is $clog2(`DWELL`+1) bits.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `pat_o`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0, dwell counter 0.
- Reset asserted mid-sweep aborts immediately with the values above. No `done` pulse is generated.
- `start` sampled high at edge E0 → `busy`=1 after E0. Sampling edges fall at E0+k·`DWELL` for k=1..2^`N_IN`.
- `done` is high during the cycle after the last sample edge. Total busy time is 2^`N_IN`·`DWELL` cycles. IDLE resumes one cycle after `done`.
- `resp_i` must settle within `DWELL` cycles of a `pat_o` change. For `DWELL`=1 it is purely combinational through the function under test.

## Configuration
- `EXHAUSTIVE_BIST_ABORT_EN` defined: adds input port `abort` (1 bit).
  - `abort`=1 in RUN forces IDLE on the next edge.
  - `busy` drops, `pass`←0, and `done` is not pulsed.
  - `pat_o` and `signature` freeze at their abort-time values.
  - `abort` is ignored in IDLE and DONE, and has priority over sweep completion on the same edge.
- Macro undefined: no `abort` port; a sweep can be stopped only by `rst_n`.

## Structure
- Shared package `bist_pkg`:
  - state enum `bist_state_t` {IDLE, RUN, DONE};
  - default `POLY` constant `BIST_POLY16` = 16'h1021;
  - function `misr_next(sig, resp, poly)`.
- One sub-module, `bist_misr`, parametrised by `SIG_W`, `N_OUT` and `POLY`. Inputs: `clk`, `rst_n`, `clr`, `en`, `resp_i`. Output: `sig`. The top holds the FSM, dwell counter and pattern counter.

## Test plan
- `N_IN`=4, `DWELL`=1, `GOLDEN`=0, `resp_i` tied 0, pulse `start` → `pat_o` steps 0..15 on consecutive cycles, `busy` high 16 cycles, `done` pulses once, `signature`=16'h0000, `pass`=1.
- Same setup, `resp_i` = AND of all `pat_o` bits → `signature`=16'h0001. With `GOLDEN`=16'h0001 → `pass`=1; with `GOLDEN`=0 → `pass`=0.
- `DWELL`=3 → each `pat_o` value held 3 cycles, `busy` high 48 cycles, `done` one cycle after the 48th.
- `rst_n` pulsed low while `pat_o`=7 → outputs go to reset values without a clock edge, no `done` pulse, next `start` restarts from `pat_o`=0.
- `start` re-pulsed during RUN → ignored, sweep length unchanged. `start` held high → back-to-back sweeps separated by one IDLE cycle.
- With `EXHAUSTIVE_BIST_ABORT_EN`: `abort` at `pat_o`=5 → IDLE next edge, `busy`=0, `pass`=0, `pat_o` frozen at 5, no `done`.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and helpers for the exhaustive BIST engine: sweep states and the MISR step.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    localparam logic [15:0] BIST_POLY16 = 16'h1021;
    localparam int          BIST_MAX_W  = 64;

    // One MISR shift: left shift, conditional polynomial feedback from the MSB,
    // then fold in the zero-extended response. Only the low w bits are meaningful.
    function automatic logic [BIST_MAX_W-1:0] misr_next(
        input logic [BIST_MAX_W-1:0] sig,
        input logic [BIST_MAX_W-1:0] resp,
        input logic [BIST_MAX_W-1:0] poly,
        input int                    w = 16
    );
        logic [BIST_MAX_W-1:0] mask;
        logic [BIST_MAX_W-1:0] nxt;
        logic                  msb;
        mask = (w >= BIST_MAX_W) ? '1 : ((BIST_MAX_W'(1) << w) - BIST_MAX_W'(1));
        msb  = |(sig & (BIST_MAX_W'(1) << (w - 1)));
        nxt  = (sig << 1) ^ (msb ? poly : '0) ^ resp;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/exhaustive_bist_if.sv
// Sequencer-side handshake and DUT stimulus/response bundle for exhaustive_bist.
// The abort input exists only when EXHAUSTIVE_BIST_ABORT_EN is defined.
interface exhaustive_bist_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter int SIG_W = 16
);
    logic              start;
    logic [N_OUT-1:0]  resp_i;
`ifdef EXHAUSTIVE_BIST_ABORT_EN
    logic              abort;
`endif
    logic [N_IN-1:0]   pat_o;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;

    modport master (
        output start,
        output resp_i,
`ifdef EXHAUSTIVE_BIST_ABORT_EN
        output abort,
`endif
        input  pat_o,
        input  busy,
        input  done,
        input  pass,
        input  signature
    );

    modport slave (
        input  start,
        input  resp_i,
`ifdef EXHAUSTIVE_BIST_ABORT_EN
        input  abort,
`endif
        output pat_o,
        output busy,
        output done,
        output pass,
        output signature
    );
endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register: clr zeroes it, en folds resp_i in on the edge.
module bist_misr
    import bist_pkg::*;
#(
    parameter int                SIG_W = 16,
    parameter int                N_OUT = 1,
    parameter logic [SIG_W-1:0]  POLY  = SIG_W'(BIST_POLY16)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [N_OUT-1:0]  resp_i,
    output logic [SIG_W-1:0]  sig
);
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = SIG_W'(misr_next(BIST_MAX_W'(sig_q), BIST_MAX_W'(resp_i),
                                     BIST_MAX_W'(POLY), SIG_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
endmodule

// File: rtl/exhaustive_bist.sv
// Exhaustive BIST sweep: steps pat_o through all 2^N_IN values, DWELL cycles each,
// compacts resp_i into a MISR and compares with GOLDEN. EXHAUSTIVE_BIST_ABORT_EN adds abort.
module exhaustive_bist
    import bist_pkg::*;
#(
    parameter int                N_IN   = 4,
    parameter int                N_OUT  = 1,
    parameter int                DWELL  = 1,
    parameter int                SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = SIG_W'(BIST_POLY16),
    parameter logic [SIG_W-1:0]  GOLDEN = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    exhaustive_bist_if.slave bus
);
    localparam int               CNT_W    = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [N_IN-1:0]  PAT_MAX  = '1;

    if (N_OUT > SIG_W) begin : g_bad_nout
        $error("exhaustive_bist: N_OUT must not exceed SIG_W");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("exhaustive_bist: DWELL must be at least 1");
    end

    bist_state_t       state_q, state_d;
    logic [N_IN-1:0]   pat_q,   pat_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              pass_q,  pass_d;
    logic              misr_clr;
    logic              misr_en;
    logic              abort_act;
    logic [SIG_W-1:0]  sig;
    logic [SIG_W-1:0]  sig_next;

`ifdef EXHAUSTIVE_BIST_ABORT_EN
    assign abort_act = bus.abort;
`else
    assign abort_act = 1'b0;
`endif

    // Signature as it will be after this edge's update, so pass is valid alongside done.
    assign sig_next = SIG_W'(misr_next(BIST_MAX_W'(sig), BIST_MAX_W'(bus.resp_i),
                                       BIST_MAX_W'(POLY), SIG_W));

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    pat_d    = '0;
                    cnt_d    = '0;
                    pass_d   = 1'b0;
                    misr_clr = 1'b1;
                end
            end
            RUN: begin
                if (abort_act) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    misr_en = 1'b1;
                    cnt_d   = '0;
                    if (pat_q == PAT_MAX) begin
                        state_d = DONE;
                        pass_d  = (sig_next == GOLDEN);
                    end else begin
                        pat_d = pat_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    bist_misr #(
        .SIG_W (SIG_W),
        .N_OUT (N_OUT),
        .POLY  (POLY)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (misr_clr),
        .en     (misr_en),
        .resp_i (bus.resp_i),
        .sig    (sig)
    );

    assign bus.pat_o     = pat_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
endmodule

// File: tb/tb_exhaustive_bist.sv
// Two engines side by side (DWELL=1/GOLDEN=1 and DWELL=3/GOLDEN=0) checked every cycle
// against a sweep-position model, plus literal expectations for the named scenarios.
module tb_exhaustive_bist;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    exhaustive_bist_if #(.N_IN(4), .N_OUT(1), .SIG_W(16)) if0 ();
    exhaustive_bist_if #(.N_IN(4), .N_OUT(1), .SIG_W(16)) if1 ();

    exhaustive_bist #(.N_IN(4), .N_OUT(1), .DWELL(1), .SIG_W(16),
                      .POLY(16'h1021), .GOLDEN(16'h0001))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    exhaustive_bist #(.N_IN(4), .N_OUT(1), .DWELL(3), .SIG_W(16),
                      .POLY(16'h1021), .GOLDEN(16'h0000))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    logic s_start [2] = '{1'b0, 1'b0};
    bit   resp_mode [2] = '{1'b0, 1'b0};
    assign if0.start  = s_start[0];
    assign if1.start  = s_start[1];
    assign if0.resp_i = resp_mode[0] ? (&if0.pat_o) : 1'b0;
    assign if1.resp_i = resp_mode[1] ? (&if1.pat_o) : 1'b0;
`ifdef EXHAUSTIVE_BIST_ABORT_EN
    logic s_abort [2] = '{1'b0, 1'b0};
    assign if0.abort = s_abort[0];
    assign if1.abort = s_abort[1];
`endif

    // Output vector layout: pat[22:19] busy[18] done[17] pass[16] sig[15:0]
    logic [22:0] o_vec [2];
    assign o_vec[0] = {if0.pat_o, if0.busy, if0.done, if0.pass, if0.signature};
    assign o_vec[1] = {if1.pat_o, if1.busy, if1.done, if1.pass, if1.signature};

    int n_cmp = 0;
    int n_err = 0;
    int bc [2] = '{0, 0};
    int dc [2] = '{0, 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dw(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] gold(input int i);
        return (i == 0) ? 16'h0001 : 16'h0000;
    endfunction

    // Signature after the first k patterns of a sweep have been sampled.
    function automatic logic [15:0] exp_sig(input int k, input bit mode);
        logic [15:0] s;
        logic [3:0]  pv;
        logic        r;
        s = 16'h0000;
        for (int p = 0; p < k; p++) begin
            pv = p[3:0];
            r  = mode & (&pv);
            s  = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, r};
        end
        return s;
    endfunction

    // Model: phase 0 idle, 1 sweeping (e = cycles since the start edge), 2 done cycle.
    int          ph   [2] = '{0, 0};
    int          e    [2] = '{0, 0};
    logic [3:0]  ipat [2] = '{4'd0, 4'd0};
    logic [15:0] isig [2] = '{16'd0, 16'd0};
    logic        ipass[2] = '{1'b0, 1'b0};
    bit          ab_m;

    function automatic logic [22:0] exp_vec(input int i);
        case (ph[i])
            1:       return {4'(e[i] / dw(i)), 1'b1, 1'b0, 1'b0,
                             exp_sig(e[i] / dw(i), resp_mode[i])};
            2:       return {ipat[i], 1'b0, 1'b1, ipass[i], isig[i]};
            default: return {ipat[i], 1'b0, 1'b0, ipass[i], isig[i]};
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
`ifdef EXHAUSTIVE_BIST_ABORT_EN
                ab_m = s_abort[i];
`else
                ab_m = 1'b0;
`endif
                case (ph[i])
                    0: if (s_start[i]) begin
                        ph[i] = 1; e[i] = 0; ipass[i] = 1'b0;
                    end
                    1: if (ab_m) begin
                        ph[i]    = 0;
                        ipat[i]  = 4'(e[i] / dw(i));
                        isig[i]  = exp_sig(e[i] / dw(i), resp_mode[i]);
                        ipass[i] = 1'b0;
                    end else begin
                        e[i]++;
                        if (e[i] == 16 * dw(i)) begin
                            ph[i]    = 2;
                            ipat[i]  = 4'd15;
                            isig[i]  = exp_sig(16, resp_mode[i]);
                            ipass[i] = (isig[i] == gold(i));
                        end
                    end
                    default: ph[i] = 0;
                endcase
            end
        end
    end

    initial forever begin
        @(negedge rst_n);
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; e[i] = 0; ipat[i] = 4'd0; isig[i] = 16'd0; ipass[i] = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cycle_dut%0d", i), 64'(o_vec[i]), 64'(exp_vec(i)));
                if (o_vec[i][18]) bc[i]++;
                if (o_vec[i][17]) dc[i]++;
            end
        end
    end

    task automatic clr_cnt();
        for (int i = 0; i < 2; i++) begin bc[i] = 0; dc[i] = 0; end
    endtask

    task automatic pulse(input bit m0, input bit m1);
        @(negedge clk);
        s_start[0] = m0; s_start[1] = m1;
        @(negedge clk);
        s_start[0] = 1'b0; s_start[1] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (o_vec[i][17]) got = 1'b1;
        end
        chk($sformatf("done_seen_dut%0d", i), 64'(got), 64'd1);
    endtask

    task automatic wait_pat0(input logic [3:0] p, input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (if0.pat_o == p) got = 1'b1;
        end
        chk("pat_reached", 64'(got), 64'd1);
    endtask

    task automatic sweep_totals(input string nm, input logic [15:0] s0, input logic p0,
                                input logic [15:0] s1, input logic p1);
        chk({nm, "_busy0"}, 64'(bc[0]), 64'd16);
        chk({nm, "_busy1"}, 64'(bc[1]), 64'd48);
        chk({nm, "_done0"}, 64'(dc[0]), 64'd1);
        chk({nm, "_done1"}, 64'(dc[1]), 64'd1);
        chk({nm, "_sig0"},  64'(if0.signature), 64'(s0));
        chk({nm, "_sig1"},  64'(if1.signature), 64'(s1));
        chk({nm, "_pass0"}, 64'(if0.pass), 64'(p0));
        chk({nm, "_pass1"}, 64'(if1.pass), 64'(p1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        chk("reset_vec0", 64'(o_vec[0]), 64'd0);
        chk("reset_vec1", 64'(o_vec[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Response tied low: signature stays zero.
        clr_cnt();
        pulse(1'b1, 1'b1);
        repeat (7) @(negedge clk);
        chk("mid_pat_dut0", 64'(if0.pat_o), 64'd7);
        chk("mid_pat_dut1", 64'(if1.pat_o), 64'd2);
        wait_done(1, 100);
        repeat (2) @(negedge clk);
        sweep_totals("zero", 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Response = AND of pattern bits: only the last pattern contributes a 1.
        resp_mode[0] = 1'b1; resp_mode[1] = 1'b1;
        clr_cnt();
        pulse(1'b1, 1'b1);
        wait_done(1, 100);
        repeat (2) @(negedge clk);
        sweep_totals("and", 16'h0001, 1'b1, 16'h0001, 1'b0);

        // Asynchronous reset mid-sweep, then a clean restart from pattern 0.
        pulse(1'b1, 1'b1);
        wait_pat0(4'd7, 30);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_vec0", 64'(o_vec[0]), 64'd0);
        chk("async_rst_vec1", 64'(o_vec[1]), 64'd0);
        clr_cnt();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_done0", 64'(dc[0]), 64'd0);
        chk("rst_no_done1", 64'(dc[1]), 64'd0);
        pulse(1'b1, 1'b0);
        chk("restart_pat", 64'(if0.pat_o), 64'd0);
        chk("restart_busy", 64'(if0.busy), 64'd1);
        wait_done(0, 40);
        chk("restart_len", 64'(bc[0]), 64'd16);

        // Start re-pulsed during a sweep has no effect.
        resp_mode[0] = 1'b0; resp_mode[1] = 1'b0;
        repeat (2) @(negedge clk);
        clr_cnt();
        pulse(1'b1, 1'b1);
        repeat (5) @(negedge clk);
        pulse(1'b1, 1'b1);
        wait_done(1, 100);
        repeat (2) @(negedge clk);
        sweep_totals("repulse", 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Start held high: back-to-back sweeps with one idle cycle between.
        clr_cnt();
        @(negedge clk);
        s_start[0] = 1'b1;
        wait_done(0, 40);
        @(negedge clk);
        chk("held_gap_busy", 64'(if0.busy), 64'd0);
        chk("held_gap_done", 64'(if0.done), 64'd0);
        @(negedge clk);
        chk("held_restart_busy", 64'(if0.busy), 64'd1);
        chk("held_restart_pat", 64'(if0.pat_o), 64'd0);
        s_start[0] = 1'b0;
        wait_done(0, 40);
        repeat (2) @(negedge clk);
        chk("held_done_count", 64'(dc[0]), 64'd2);

`ifdef EXHAUSTIVE_BIST_ABORT_EN
        resp_mode[0] = 1'b1;
        clr_cnt();
        pulse(1'b1, 1'b0);
        wait_pat0(4'd5, 30);
        s_abort[0] = 1'b1;
        @(negedge clk);
        s_abort[0] = 1'b0;
        chk("abort_busy", 64'(if0.busy), 64'd0);
        chk("abort_pat", 64'(if0.pat_o), 64'd5);
        chk("abort_pass", 64'(if0.pass), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(dc[0]), 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
